// File: rtl/servo_pwm_multi.sv
// Multi-channel fixed-period servo PWM generator with one shared period counter.
// Widths are clamped on write and applied (optionally slew-limited) only at period boundaries.
module servo_pwm_multi #(
   parameter int CH       = 2,
   parameter int CNT_W    = 18,
   parameter int PERIOD   = 240000,
   parameter int DUTY_MIN = 12000,
   parameter int DUTY_MAX = 24000,
   parameter int DUTY_RST = 18000,
   parameter int STEP_MAX = 0,
   localparam int CH_W    = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             wr_en,
   input  logic [CH_W-1:0]  wr_ch,
   input  logic [CNT_W-1:0] wr_duty,
   output logic [CH-1:0]    pwm_out,
   output logic             period_start,
   output logic             settled
);

   localparam logic [CNT_W-1:0] L_MIN  = CNT_W'(DUTY_MIN);
   localparam logic [CNT_W-1:0] L_MAX  = CNT_W'(DUTY_MAX);
   localparam logic [CNT_W-1:0] L_RST  = CNT_W'(DUTY_RST);
   localparam logic [CNT_W-1:0] L_STEP = CNT_W'(STEP_MAX);
   localparam logic [CNT_W-1:0] L_LAST = CNT_W'(PERIOD - 1);
   localparam logic [CH_W:0]    L_CH   = (CH_W + 1)'(CH);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_target [CH];
   logic [CNT_W-1:0] r_act    [CH];
   logic [CH-1:0]    r_pwm;
   logic             r_period_start;
   logic             r_settled;

   logic [CNT_W-1:0] w_tgt_next [CH];
   logic [CNT_W-1:0] w_act_next [CH];
   logic [CH-1:0]    w_eq;
   logic [CH-1:0]    w_pwm_next;
   logic [CNT_W-1:0] w_duty_clamped;
   logic             w_boundary;
   logic             w_wr_ok;

   assign w_boundary = en && (r_cnt == L_LAST);
   assign w_wr_ok    = wr_en && ({1'b0, wr_ch} < L_CH);

   always_comb begin
      w_duty_clamped = wr_duty;
      if (wr_duty < L_MIN)
         w_duty_clamped = L_MIN;
      else if (wr_duty > L_MAX)
         w_duty_clamped = L_MAX;
   end

   generate
      for (genvar gi = 0; gi < CH; gi++) begin : g_ch
         logic             w_hit;
         logic             w_up;
         logic [CNT_W-1:0] w_diff;
         logic [CNT_W-1:0] w_delta;
         logic [CNT_W-1:0] w_act_slew;

         assign w_hit   = w_wr_ok && (wr_ch == CH_W'(gi));
         assign w_up    = r_target[gi] > r_act[gi];
         assign w_diff  = w_up ? (r_target[gi] - r_act[gi]) : (r_act[gi] - r_target[gi]);
         // With no slew limit the full distance is taken, landing exactly on target.
         assign w_delta = ((STEP_MAX == 0) || (w_diff <= L_STEP)) ? w_diff : L_STEP;
         assign w_act_slew = w_up ? (r_act[gi] + w_delta) : (r_act[gi] - w_delta);

         // The boundary update reads the old target; a same-cycle write lands next period.
         assign w_act_next[gi] = w_boundary ? w_act_slew : r_act[gi];
         assign w_tgt_next[gi] = w_hit ? w_duty_clamped : r_target[gi];
         assign w_eq[gi]       = (w_act_next[gi] == w_tgt_next[gi]);
         assign w_pwm_next[gi] = en && (r_cnt < r_act[gi]);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt          <= '0;
         r_pwm          <= '0;
         r_period_start <= 1'b0;
         r_settled      <= 1'b1;
         for (int i = 0; i < CH; i++) begin
            r_target[i] <= L_RST;
            r_act[i]    <= L_RST;
         end
      end else begin
         if (!en || (r_cnt == L_LAST))
            r_cnt <= '0;
         else
            r_cnt <= r_cnt + 1'b1;
         r_pwm          <= w_pwm_next;
         r_period_start <= en && (r_cnt == '0);
         r_settled      <= &w_eq;
         for (int i = 0; i < CH; i++) begin
            r_target[i] <= w_tgt_next[i];
            r_act[i]    <= w_act_next[i];
         end
      end
   end

   assign pwm_out      = r_pwm;
   assign period_start = r_period_start;
   assign settled      = r_settled;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Bench for servo_pwm_multi: two instances (no slew, CH=2; slew 15, CH=3) share stimulus
// and are checked every cycle against a per-period width model plus directed width measurements.
module tb_servo_pwm_multi;

   localparam int CNT_W  = 8;
   localparam int PERIOD = 100;
   localparam int DMIN   = 10;
   localparam int DMAX   = 90;
   localparam int DRST   = 50;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en = 1'b0;
   logic             wr_en0 = 1'b0;
   logic             wr_en1 = 1'b0;
   logic [0:0]       wr_ch0 = '0;
   logic [1:0]       wr_ch1 = '0;
   logic [CNT_W-1:0] wr_duty = '0;
   logic [1:0]       pwm0;
   logic [2:0]       pwm1;
   logic             ps0, ps1, set0, set1;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_on  = 1'b0;

   // Reference state: shared period position, per-instance targets/active widths.
   int m_cnt;
   int m_act [2][3];
   int m_tgt [2][3];
   int m_pwm [2];
   int m_ps;
   int m_set [2];
   int nch  [2] = '{2, 3};
   int step [2] = '{0, 15};

   always #5 clk = ~clk;

   servo_pwm_multi #(.CH(2), .CNT_W(CNT_W), .PERIOD(PERIOD), .DUTY_MIN(DMIN), .DUTY_MAX(DMAX),
                     .DUTY_RST(DRST), .STEP_MAX(0)) dut0 (
      .clk(clk), .rst(rst), .en(en), .wr_en(wr_en0), .wr_ch(wr_ch0), .wr_duty(wr_duty),
      .pwm_out(pwm0), .period_start(ps0), .settled(set0));

   servo_pwm_multi #(.CH(3), .CNT_W(CNT_W), .PERIOD(PERIOD), .DUTY_MIN(DMIN), .DUTY_MAX(DMAX),
                     .DUTY_RST(DRST), .STEP_MAX(15)) dut1 (
      .clk(clk), .rst(rst), .en(en), .wr_en(wr_en1), .wr_ch(wr_ch1), .wr_duty(wr_duty),
      .pwm_out(pwm1), .period_start(ps1), .settled(set1));

   task automatic check_val(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int clamp(input int v);
      return (v < DMIN) ? DMIN : ((v > DMAX) ? DMAX : v);
   endfunction

   function automatic int slew(input int act, input int tgt, input int s);
      int d;
      d = tgt - act;
      if (s != 0 && d > s)  d = s;
      if (s != 0 && d < -s) d = -s;
      return act + d;
   endfunction

   // Model advances on the same edge the DUTs do, using the inputs held since the last negedge.
   always @(posedge clk) begin
      if (rst) begin
         m_cnt = 0;
         m_ps  = 0;
         for (int m = 0; m < 2; m++) begin
            m_pwm[m] = 0;
            m_set[m] = 1;
            for (int i = 0; i < 3; i++) begin
               m_act[m][i] = DRST;
               m_tgt[m][i] = DRST;
            end
         end
      end else begin
         for (int m = 0; m < 2; m++) begin
            m_pwm[m] = 0;
            for (int i = 0; i < nch[m]; i++)
               if (en && m_cnt < m_act[m][i]) m_pwm[m] |= (1 << i);
         end
         m_ps = (en && m_cnt == 0) ? 1 : 0;
         if (en && m_cnt == PERIOD - 1)
            for (int m = 0; m < 2; m++)
               for (int i = 0; i < nch[m]; i++)
                  m_act[m][i] = slew(m_act[m][i], m_tgt[m][i], step[m]);
         if (wr_en0) m_tgt[0][int'(wr_ch0)] = clamp(int'(wr_duty));
         if (wr_en1 && int'(wr_ch1) < 3) m_tgt[1][int'(wr_ch1)] = clamp(int'(wr_duty));
         m_cnt = (!en || m_cnt == PERIOD - 1) ? 0 : m_cnt + 1;
         for (int m = 0; m < 2; m++) begin
            m_set[m] = 1;
            for (int i = 0; i < nch[m]; i++)
               if (m_act[m][i] != m_tgt[m][i]) m_set[m] = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         check_val("pwm0", int'(pwm0), m_pwm[0]);
         check_val("ps0", int'(ps0), m_ps);
         check_val("settled0", int'(set0), m_set[0]);
         check_val("pwm1", int'(pwm1), m_pwm[1]);
         check_val("ps1", int'(ps1), m_ps);
         check_val("settled1", int'(set1), m_set[1]);
      end
   end

   // Invalid channel index only exists for the CH=3 instance (index 3).
   task automatic wr_now(input int ch, input int duty);
      wr_en0  = (ch < 2);
      wr_en1  = 1'b1;
      wr_ch0  = ch[0];
      wr_ch1  = ch[1:0];
      wr_duty = duty[CNT_W-1:0];
      @(negedge clk);
      wr_en0 = 1'b0;
      wr_en1 = 1'b0;
   endtask

   task automatic wait_cnt(input int k);
      for (int i = 0; i < 4 * PERIOD; i++) begin
         if (m_cnt == k) return;
         @(negedge clk);
      end
      check_val("wait_cnt_timeout", 0, 1);
   endtask

   task automatic measure(input int d, input int ch, output int w);
      int n = 0;
      while (!(d == 0 ? ps0 : ps1)) begin
         @(negedge clk);
         n++;
         if (n > 3 * PERIOD) begin
            check_val("period_start_timeout", 0, 1);
            w = -1;
            return;
         end
      end
      w = 0;
      for (int i = 0; i < PERIOD; i++) begin
         if (d == 0 ? pwm0[ch] : pwm1[ch]) w++;
         @(negedge clk);
      end
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   int w;

   initial begin
      repeat (2) @(negedge clk);
      chk_on = 1'b1;
      check_val("rst_pwm", int'(pwm0), 0);
      check_val("rst_ps", int'(ps0), 0);
      check_val("rst_settled", int'(set0), 1);
      rst = 1'b0;
      en  = 1'b1;

      measure(0, 0, w); check_val("s1_ch0", w, 50);
      measure(0, 1, w); check_val("s1_ch1", w, 50);
      measure(1, 0, w); check_val("s1_slew_ch0", w, 50);

      wait_cnt(40); wr_now(0, 30);
      measure(0, 0, w); check_val("s2_ch0", w, 30);
      measure(0, 1, w); check_val("s2_ch1", w, 50);

      wait_cnt(10); wr_now(1, 5);
      measure(0, 1, w); check_val("s3_clamp_lo", w, 10);
      wait_cnt(10); wr_now(1, 200);
      measure(0, 1, w); check_val("s3_clamp_hi", w, 90);

      wait_cnt(PERIOD - 1);
      wr_en0 = 1'b1; wr_en1 = 1'b1; wr_ch0 = 1'b0; wr_ch1 = 2'd0; wr_duty = 8'd60;
      @(negedge clk);
      wr_duty = 8'd70;
      @(negedge clk);
      wr_en0 = 1'b0; wr_en1 = 1'b0;
      measure(0, 0, w); check_val("s4_late_old", w, 30);
      measure(0, 0, w); check_val("s4_last_wins", w, 70);
      wait_cnt(PERIOD - 1); wr_now(0, 20);
      measure(0, 0, w); check_val("s4_single_old", w, 70);
      measure(0, 0, w); check_val("s4_single_new", w, 20);

      reset_pulse();
      wait_cnt(10); wr_now(3, 20);
      check_val("s3_invalid_settled", int'(set1), 1);
      measure(1, 0, w); check_val("s3_invalid_ch0", w, 50);

      wait_cnt(10); wr_now(0, 90);
      check_val("s5_unsettled", int'(set1), 0);
      measure(1, 0, w); check_val("s5_ramp1", w, 65);
      check_val("s5_still_unsettled", int'(set1), 0);
      measure(1, 0, w); check_val("s5_ramp2", w, 80);
      check_val("s5_settled", int'(set1), 1);
      measure(1, 0, w); check_val("s5_ramp3", w, 90);

      reset_pulse();
      wait_cnt(30);
      en = 1'b0;
      @(negedge clk);
      check_val("s6_off_pwm0", int'(pwm0), 0);
      check_val("s6_off_pwm1", int'(pwm1), 0);
      wr_now(0, 40);
      repeat (5) @(negedge clk);
      en = 1'b1;
      measure(0, 0, w); check_val("s6_first", w, 50);
      measure(0, 0, w); check_val("s6_second", w, 40);
      wait_cnt(10); wr_now(0, 90);
      measure(1, 0, w);
      wait_cnt(50);
      reset_pulse();
      check_val("s6_rst_settled0", int'(set0), 1);
      check_val("s6_rst_settled1", int'(set1), 1);
      measure(1, 0, w); check_val("s6_rst_ch0", w, 50);

      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         rst     = ($urandom_range(999) == 0);
         if ($urandom_range(199) == 0) en = ~en;
         wr_en0  = ($urandom_range(15) == 0);
         wr_en1  = ($urandom_range(15) == 0);
         wr_ch0  = 1'($urandom_range(1));
         wr_ch1  = 2'($urandom_range(3));
         wr_duty = 8'($urandom_range(255));
      end
      @(negedge clk);
      wr_en0 = 1'b0;
      wr_en1 = 1'b0;
      rst    = 1'b0;
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
